// File: rtl/traffic_pkg.sv
// Shared lamp codes, fault codes and tracker states for the intersection
// conflict monitor.
package traffic_pkg;

  localparam logic [2:0] GREEN  = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  localparam logic [3:0] ALL_RED_STATE = 4'h6;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_CONFLICT     = 3'd1,
    FC_INVALID      = 3'd2,
    FC_NO_YELLOW    = 3'd3,
    FC_SHORT_YELLOW = 3'd4,
    FC_DARK         = 3'd5
  } fault_code_t;

  typedef enum logic [1:0] {
    TRK_UNKNOWN,
    TRK_GREEN,
    TRK_YELLOW,
    TRK_RED
  } trk_state_t;

  // A lamp showing green or yellow lets traffic move.
  function automatic logic is_go(input logic [2:0] code);
    return (code == GREEN) || (code == YELLOW);
  endfunction

  function automatic logic is_multi(input logic [2:0] code);
    return (code[2] & code[1]) | (code[2] & code[0]) | (code[1] & code[0]);
  endfunction

endpackage

// File: rtl/approach_tracker.sv
// Per-approach lamp sequence tracker: follows GREEN/YELLOW/RED and flags red
// entries that skip yellow or cut the yellow phase short.
module approach_tracker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] i_code,
  input  logic       i_tick,
  input  logic       i_en,
  output trk_state_t o_state,
  output logic       o_to_red_from_green,
  output logic       o_short_yellow
);

  localparam int            YW    = $clog2(MIN_YELLOW + 1);
  localparam logic [YW-1:0] Y_MIN = YW'(MIN_YELLOW);

  trk_state_t    r_state;
  logic [YW-1:0] r_ycnt;
  logic          w_ytick;
  logic          w_red;

  assign w_ytick = i_tick && (r_state == TRK_YELLOW) && (r_ycnt != Y_MIN);
  assign w_red   = i_en && (i_code == RED);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= TRK_UNKNOWN;
      r_ycnt  <= '0;
    end else if (!i_en) begin
      r_state <= TRK_UNKNOWN;
      r_ycnt  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (i_code)
        GREEN:  r_state <= TRK_GREEN;
        YELLOW: begin
          r_state <= TRK_YELLOW;
          if (r_state != TRK_YELLOW) r_ycnt <= '0;
          else if (w_ytick)          r_ycnt <= r_ycnt + 1'b1;
        end
        RED:    r_state <= TRK_RED;
        // Dark or invalid codes hold the phase, so a blinking yellow keeps timing.
        default: if (w_ytick) r_ycnt <= r_ycnt + 1'b1;
      endcase
    end
  end

  assign o_state             = r_state;
  assign o_to_red_from_green = w_red && (r_state == TRK_GREEN);
  assign o_short_yellow      = w_red && (r_state == TRK_YELLOW) && (r_ycnt < Y_MIN);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Conflict monitor for intersection lamp outputs: latches the first illegal
// lamp combination or sequence and forces the controller into all-red.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int TICK_DIV      = 500000,
  parameter int CONFLICT_FILT = 4,
  parameter int MIN_YELLOW    = 3,
  parameter int DARK_TICKS    = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] north_south,
  input  logic [2:0] east_west,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count,
  output logic       force_ld,
  output logic [3:0] force_data
);

  localparam int            PW     = $clog2(TICK_DIV);
  localparam int            FW     = $clog2(CONFLICT_FILT + 1);
  localparam int            DW     = $clog2(DARK_TICKS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(CONFLICT_FILT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DARK_TICKS - 1);

  logic [2:0]    r_ns, r_ew;
  logic [PW-1:0] r_presc;
  logic [FW-1:0] r_conf_cnt, r_inv_cnt;
  logic [DW-1:0] r_dark_cnt;
  logic          r_fault;
  fault_code_t   r_code;
  logic [7:0]    r_count;

  logic        w_tick, w_conf_raw, w_inv_raw, w_dark_raw, w_raw_any;
  logic        w_ns_g2r, w_ns_short, w_ew_g2r, w_ew_short;
  fault_code_t w_code;
  trk_state_t  w_unused_ns_state, w_unused_ew_state;

  assign w_tick     = en && (r_presc == P_LAST);
  assign w_conf_raw = en && is_go(r_ns) && is_go(r_ew);
  assign w_inv_raw  = en && (is_multi(r_ns) || is_multi(r_ew));
  assign w_dark_raw = en && (r_ns == OFF) && (r_ew == OFF);

  approach_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_ns (
    .clk(clk), .rst_(rst_), .i_code(r_ns), .i_tick(w_tick), .i_en(en),
    .o_state(w_unused_ns_state), .o_to_red_from_green(w_ns_g2r), .o_short_yellow(w_ns_short)
  );

  approach_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_ew (
    .clk(clk), .rst_(rst_), .i_code(r_ew), .i_tick(w_tick), .i_en(en),
    .o_state(w_unused_ew_state), .o_to_red_from_green(w_ew_g2r), .o_short_yellow(w_ew_short)
  );

  // Clear is refused while any detector still sees a fault condition.
  assign w_raw_any = w_conf_raw || w_inv_raw || w_dark_raw ||
                     w_ns_g2r || w_ew_g2r || w_ns_short || w_ew_short;

  always_comb begin
    // NOTE: default assigned first so every path drives w_code and no latch is inferred.
    w_code = FC_NONE;
    if (w_conf_raw && (r_conf_cnt == F_LAST))                w_code = FC_CONFLICT;
    else if (w_inv_raw && (r_inv_cnt == F_LAST))             w_code = FC_INVALID;
    else if (w_ns_g2r || w_ew_g2r)                           w_code = FC_NO_YELLOW;
    else if (w_ns_short || w_ew_short)                       w_code = FC_SHORT_YELLOW;
    else if (w_dark_raw && w_tick && (r_dark_cnt == D_LAST)) w_code = FC_DARK;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_ns       <= OFF;
      r_ew       <= OFF;
      r_presc    <= '0;
      r_conf_cnt <= '0;
      r_inv_cnt  <= '0;
      r_dark_cnt <= '0;
    end else begin
      r_ns       <= north_south;
      r_ew       <= east_west;
      r_presc    <= (!en || w_tick) ? '0 : r_presc + 1'b1;
      r_conf_cnt <= !w_conf_raw ? '0 : (r_conf_cnt == F_LAST) ? r_conf_cnt : r_conf_cnt + 1'b1;
      r_inv_cnt  <= !w_inv_raw  ? '0 : (r_inv_cnt  == F_LAST) ? r_inv_cnt  : r_inv_cnt  + 1'b1;
      if (!w_dark_raw)                          r_dark_cnt <= '0;
      else if (w_tick && (r_dark_cnt != D_LAST)) r_dark_cnt <= r_dark_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
      r_count <= '0;
    end else if (!r_fault) begin
      if (w_code != FC_NONE) begin
        r_fault <= 1'b1;
        r_code  <= w_code;
        if (r_count != 8'hFF) r_count <= r_count + 1'b1;
      end
    end else if (clr && !w_raw_any) begin
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
    end
  end

  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign fault_count = r_count;
  assign force_ld    = r_fault;
  assign force_data  = r_fault ? ALL_RED_STATE : 4'h0;

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Independent conflict monitor on the receiving end of the intersection light outputs. It observes the north-south and east-west 3-bit lamp codes driven by the traffic controller and checks for illegal combinations and illegal sequencing. The first fault is latched, and the monitor then holds a forced all-red load request (ld/data) back into the controller until an operator clear is accepted.

## Interface
- TICK_DIV, 500000: clk cycles per timing tick; must be ≥2.
- CONFLICT_FILT, 4: consecutive cycles a conflict or invalid code must persist before it faults; must be ≥1.
- MIN_YELLOW, 3: minimum ticks of yellow phase before red.
- DARK_TICKS, 2: consecutive ticks with both approaches off that constitute a dark fault.
- clk  in  1  clock.
- rst_  in  1  reset, asynchronous, active-low.
- en  in  1  monitor enable.
- clr  in  1  fault clear request, single-cycle pulse.
- north_south  in  3  lamp code: green 100, yellow 010, red 001, off 000.
- east_west  in  3  lamp code, same encoding.
- fault  out  1  latched fault.
- fault_code  out  3  0 none, 1 conflict, 2 invalid code, 3 green→red with no yellow, 4 short yellow, 5 dark.
- fault_count  out  8  saturating count of latched faults; stops at 255.
- force_ld  out  1  equals fault; drives the controller ld.
- force_data  out  4  4'h6 (all-red state) while force_ld=1, otherwise 4'h0.

## Operation
- Both lamp inputs are registered once. All detection uses the registered copies.
- Prescaler counts 0..TICK_DIV-1. It emits a one-cycle tick on the wrap and runs only while en=1.
- Per-approach tracker states: UNKNOWN, GREEN, YELLOW, RED.
  - Code 100 → GREEN. Code 010 → YELLOW. Code 001 → RED.
  - Code 000 leaves the state unchanged, so blinking yellow stays in YELLOW.
  - Invalid codes (more than one bit set) leave the state unchanged.
  - Entering YELLOW clears the yellow tick counter. Each tick while in YELLOW increments it, saturating at MIN_YELLOW.
- Conflict: both registered codes are in {100, 010} for CONFLICT_FILT consecutive cycles → code 1.
- Invalid: either code has more than one bit set for CONFLICT_FILT consecutive cycles → code 2.
- Transitions into RED:
  - GREEN→RED → code 3.
  - YELLOW→RED with yellow ticks < MIN_YELLOW → code 4.
  - UNKNOWN→RED and RED→RED are legal.
- Dark: both codes 000 → dark tick counter increments per tick. It resets when either code is non-zero. Reaching DARK_TICKS → code 5.
- Priority when several faults fire on the same edge: lowest code wins.
- Only the first fault is latched. Later faults are ignored while fault=1.
- fault_count increments only on a 0→1 transition of fault.
- Clear:
  - clr is accepted only when fault=1 and no raw detector condition is active. Acceptance clears fault, fault_code and force_ld.
  - clr is ignored otherwise.
  - clr and a new fault on the same edge: the fault wins.
- en=0:
  - Holds the prescaler, filters, dark counter and yellow counters at 0, and the trackers at UNKNOWN.
  - The latched fault, fault_code and fault_count are retained, and clr still works.
  - Emergency controller states (all-green, all-yellow) must only be run with en=0.

## Timing
- Reset values (async on rst_ low): fault=0, fault_code=0, fault_count=0, force_ld=0, force_data=0. Trackers are UNKNOWN and all counters are 0.
- Reset asserted mid-operation clears the latched fault immediately.
- Conflict or invalid condition held from cycle 0: fault=1 after rising edge CONFLICT_FILT+1. A condition lasting fewer than CONFLICT_FILT registered cycles never faults.
- Sequence faults (codes 3, 4): fault=1 two edges after the offending code appears at the input (input register, then tracker compare).
- Dark fault: asserts on the edge after the DARK_TICKS-th qualifying tick.
- force_ld and force_data change on the same edge as fault.
- Accepted clr: outputs clear on the next edge.

## Structure
- Package traffic_pkg holds:
  - lamp code constants GREEN, YELLOW, RED, OFF;
  - fault code constants;
  - tracker state encoding;
  - ALL_RED_STATE = 4'h6.
- Sub-module approach_tracker, instantiated twice:
  - inputs: registered code, tick, en;
  - outputs: state, to_red_from_green pulse, short_yellow pulse.
- The top level contains the prescaler, conflict/invalid filters, dark counter, priority encoder and latch.

## Test plan
- Normal cycle: NS 100 for 5 ticks, then 010 for 3 ticks, then 001; EW mirrored. Required: fault stays 0 throughout.
- Conflict with CONFLICT_FILT=4:
  - NS=100 and EW=010 for 3 cycles → no fault.
  - Same condition held 4 cycles → fault=1, fault_code=1, force_data=4'h6.
- Short yellow: NS 100 → 010 for 2 ticks → 001. Required: fault_code=4. Repeating with a blinking 010/000 yellow for 3 ticks gives no fault.
- Direct and invalid:
  - NS 100 → 001 → fault_code=3.
  - After reset, NS=110 for 4 cycles → fault_code=2.
- Dark and clear:
  - Both 000 for 2 ticks → fault_code=5.
  - clr while still dark → ignored.
  - Restore EW=001, then clr → fault=0 next edge; fault_count stays 1.
- Enable and reset: with en=0, drive a conflict → no fault. Assert rst_ while fault=1 → all outputs 0 immediately.
